// File: rtl/rtable_pkg.sv
// rtable_pkg: shared types and constants for the grid-world reward/transition generator.
//   cls_e      - outcome class of one lookup (priority WALL > OBST > GOAL > NONE)
//   cfg_sel_e  - config register select codes
//   FP_*       - float32 reset defaults for the reward registers
//   act_delta  - action -> {dx,dy} table for king (8) and rook (4) move sets
package rtable_pkg;

  typedef enum logic [1:0] {
    ClsNone = 2'd0,
    ClsWall = 2'd1,
    ClsObst = 2'd2,
    ClsGoal = 2'd3
  } cls_e;

  typedef enum logic [2:0] {
    CfgRWall      = 3'd0,
    CfgRGoal      = 3'd1,
    CfgRDef       = 3'd2,
    CfgRObst      = 3'd3,
    CfgGoal       = 3'd4,
    CfgObstSet    = 3'd5,
    CfgObstClr    = 3'd6,
    CfgObstClrAll = 3'd7
  } cfg_sel_e;

  localparam logic [31:0] FP_NEG_255 = 32'hC37F_0000;
  localparam logic [31:0] FP_POS_255 = 32'h437F_0000;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

  // Returns {dx[1:0], dy[1:0]}, each a 2-bit two's complement value in {-1,0,+1}.
  function automatic logic [3:0] act_delta(input logic [2:0] act, input logic rook);
    logic [3:0] d;
    d = 4'b00_00;
    if (rook) begin
      case (act)
        3'd0:    d = 4'b11_00;  // (-1, 0)
        3'd1:    d = 4'b00_11;  // ( 0,-1)
        3'd2:    d = 4'b01_00;  // (+1, 0)
        3'd3:    d = 4'b00_01;  // ( 0,+1)
        default: d = 4'b00_00;
      endcase
    end else begin
      case (act)
        3'd0:    d = 4'b11_00;  // (-1, 0)
        3'd1:    d = 4'b11_11;  // (-1,-1)
        3'd2:    d = 4'b00_11;  // ( 0,-1)
        3'd3:    d = 4'b01_11;  // (+1,-1)
        3'd4:    d = 4'b01_00;  // (+1, 0)
        3'd5:    d = 4'b01_01;  // (+1,+1)
        3'd6:    d = 4'b00_01;  // ( 0,+1)
        default: d = 4'b11_01;  // (-1,+1)
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/rtable_gen_if.sv
// rtable_gen_if: lookup, result and config signals of rtable_gen.
//   i_stall            - freeze both pipeline stages
//   i_valid/i_state/i_act - per-channel lookup request
//   i_cfg_we/sel/data  - config write port
//   o_valid/o_data/o_next/o_term - per-channel result
// master: the requester side; slave: the generator.
interface rtable_gen_if #(
  parameter int unsigned COORD_W    = 3,
  parameter int unsigned ACT_W      = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 2
);

  logic                            i_stall;
  logic [NUM_CH-1:0]               i_valid;
  logic [NUM_CH*2*COORD_W-1:0]     i_state;
  logic [NUM_CH*ACT_W-1:0]         i_act;
  logic                            i_cfg_we;
  logic [2:0]                      i_cfg_sel;
  logic [DATA_WIDTH-1:0]           i_cfg_data;
  logic [NUM_CH-1:0]               o_valid;
  logic [NUM_CH*DATA_WIDTH-1:0]    o_data;
  logic [NUM_CH*2*COORD_W-1:0]     o_next;
  logic [NUM_CH-1:0]               o_term;

  modport master (
    output i_stall, i_valid, i_state, i_act, i_cfg_we, i_cfg_sel, i_cfg_data,
    input  o_valid, o_data, o_next, o_term
  );

  modport slave (
    input  i_stall, i_valid, i_state, i_act, i_cfg_we, i_cfg_sel, i_cfg_data,
    output o_valid, o_data, o_next, o_term
  );

endinterface

// File: rtl/rtable_lane.sv
// rtable_lane: one lookup channel, combinational classification plus the stage-1 register.
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_stall             - hold stage-1 contents
//   i_valid/i_state/i_act - lookup request, state = {x,y}
//   i_goal, i_obst_map  - shared goal position and obstacle bitmap ({x,y} indexed)
//   i_r_wall/goal/def/obst - shared reward values
//   o_valid/o_data/o_next/o_term - stage-1 registered result
module rtable_lane
  import rtable_pkg::*;
#(
  parameter int unsigned COORD_W    = 3,
  parameter int unsigned NUM_ACT    = 8,
  parameter int unsigned ACT_W      = 3,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_stall,
  input  logic                            i_valid,
  input  logic [2*COORD_W-1:0]            i_state,
  input  logic [ACT_W-1:0]                i_act,
  input  logic [2*COORD_W-1:0]            i_goal,
  input  logic [(1<<(2*COORD_W))-1:0]     i_obst_map,
  input  logic [DATA_WIDTH-1:0]           i_r_wall,
  input  logic [DATA_WIDTH-1:0]           i_r_goal,
  input  logic [DATA_WIDTH-1:0]           i_r_def,
  input  logic [DATA_WIDTH-1:0]           i_r_obst,
  output logic                            o_valid,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic [2*COORD_W-1:0]            o_next,
  output logic                            o_term
);

  localparam bit Rook = (NUM_ACT == 32'd4);

  logic [2:0]             w_act3;
  logic [3:0]             w_delta;
  logic [COORD_W-1:0]     w_x, w_y;
  logic [COORD_W:0]       w_nx, w_ny;
  logic                   w_wall;
  logic [2*COORD_W-1:0]   w_cand;
  cls_e                   w_cls;
  logic [2*COORD_W-1:0]   w_next;
  logic [DATA_WIDTH-1:0]  w_reward;

  logic                   r_valid;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [2*COORD_W-1:0]   r_next;
  logic                   r_term;

  assign w_act3  = 3'(i_act);
  assign w_delta = act_delta(w_act3, Rook);
  assign w_x     = i_state[2*COORD_W-1:COORD_W];
  assign w_y     = i_state[COORD_W-1:0];

  // COORD_W+1-bit signed sum: both -1 and 2^COORD_W land with the MSB set, legal 0..MAX do not.
  assign w_nx   = {1'b0, w_x} + {{(COORD_W-1){w_delta[3]}}, w_delta[3:2]};
  assign w_ny   = {1'b0, w_y} + {{(COORD_W-1){w_delta[1]}}, w_delta[1:0]};
  assign w_wall = w_nx[COORD_W] | w_ny[COORD_W];
  assign w_cand = {w_nx[COORD_W-1:0], w_ny[COORD_W-1:0]};

  always_comb begin
    w_cls = ClsNone;
    if (w_wall)                  w_cls = ClsWall;
    else if (i_obst_map[w_cand]) w_cls = ClsObst;
    else if (w_cand == i_goal)   w_cls = ClsGoal;
  end

  always_comb begin
    w_reward = '0;
    w_next   = w_cand;
    unique case (w_cls)
      ClsWall: begin w_reward = i_r_wall; w_next = i_state; end
      ClsObst: begin w_reward = i_r_obst; w_next = i_state; end
      ClsGoal: w_reward = i_r_goal;
      ClsNone: w_reward = i_r_def;
    endcase
  end

  // Data fields only load on a valid lookup so idle channels hold their last result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_next  <= '0;
      r_term  <= 1'b0;
    end else if (!i_stall) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_reward;
        r_next <= w_next;
        r_term <= (w_cls == ClsGoal);
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_next  = r_next;
  assign o_term  = r_term;

endmodule

// File: rtl/rtable_gen.sv
// rtable_gen: runtime-configurable reward/transition generator for the Q-learning grid world.
// NUM_CH independent lookups per cycle, 2-cycle latency, fully pipelined.
//   i_clk  - clock
//   i_rst  - synchronous active-high reset (overrides stall, restores config defaults)
//   io_bus - rtable_gen_if slave: lookup request, config port, result outputs
module rtable_gen
  import rtable_pkg::*;
#(
  parameter int unsigned COORD_W    = 3,
  parameter int unsigned NUM_ACT    = 8,
  parameter int unsigned ACT_W      = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 2
) (
  input logic         i_clk,
  input logic         i_rst,
  rtable_gen_if.slave io_bus
);

  localparam int unsigned MapBits = 1 << (2 * COORD_W);

  logic [DATA_WIDTH-1:0]        r_r_wall, r_r_goal, r_r_def, r_r_obst;
  logic [2*COORD_W-1:0]         r_goal;
  logic [MapBits-1:0]           r_obst_map;
  logic [2*COORD_W-1:0]         w_cfg_idx;

  logic [NUM_CH-1:0]            w_s1_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] w_s1_data;
  logic [NUM_CH*2*COORD_W-1:0]  w_s1_next;
  logic [NUM_CH-1:0]            w_s1_term;

  logic [NUM_CH-1:0]            r_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] r_data;
  logic [NUM_CH*2*COORD_W-1:0]  r_next;
  logic [NUM_CH-1:0]            r_term;

  assign w_cfg_idx = io_bus.i_cfg_data[2*COORD_W-1:0];

  // Config port ignores i_stall; lanes read these registers combinationally, so a
  // lookup in the write cycle still sees the old value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_r_wall   <= DATA_WIDTH'(FP_NEG_255);
      r_r_goal   <= DATA_WIDTH'(FP_POS_255);
      r_r_def    <= DATA_WIDTH'(FP_ZERO);
      r_r_obst   <= DATA_WIDTH'(FP_NEG_255);
      r_goal     <= '1;
      r_obst_map <= '0;
    end else if (io_bus.i_cfg_we) begin
      case (io_bus.i_cfg_sel)
        CfgRWall:      r_r_wall <= io_bus.i_cfg_data;
        CfgRGoal:      r_r_goal <= io_bus.i_cfg_data;
        CfgRDef:       r_r_def  <= io_bus.i_cfg_data;
        CfgRObst:      r_r_obst <= io_bus.i_cfg_data;
        CfgGoal:       r_goal   <= w_cfg_idx;
        CfgObstSet:    r_obst_map[w_cfg_idx] <= 1'b1;
        CfgObstClr:    r_obst_map[w_cfg_idx] <= 1'b0;
        CfgObstClrAll: r_obst_map <= '0;
        default:       ;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    rtable_lane #(
      .COORD_W    (COORD_W),
      .NUM_ACT    (NUM_ACT),
      .ACT_W      (ACT_W),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_stall    (io_bus.i_stall),
      .i_valid    (io_bus.i_valid[k]),
      .i_state    (io_bus.i_state[k*2*COORD_W +: 2*COORD_W]),
      .i_act      (io_bus.i_act[k*ACT_W +: ACT_W]),
      .i_goal     (r_goal),
      .i_obst_map (r_obst_map),
      .i_r_wall   (r_r_wall),
      .i_r_goal   (r_r_goal),
      .i_r_def    (r_r_def),
      .i_r_obst   (r_r_obst),
      .o_valid    (w_s1_valid[k]),
      .o_data     (w_s1_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_next     (w_s1_next[k*2*COORD_W +: 2*COORD_W]),
      .o_term     (w_s1_term[k])
    );
  end

  // Stage 2: plain output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      r_data  <= '0;
      r_next  <= '0;
      r_term  <= '0;
    end else if (!io_bus.i_stall) begin
      r_valid <= w_s1_valid;
      r_data  <= w_s1_data;
      r_next  <= w_s1_next;
      r_term  <= w_s1_term;
    end
  end

  assign io_bus.o_valid = r_valid;
  assign io_bus.o_data  = r_data;
  assign io_bus.o_next  = r_next;
  assign io_bus.o_term  = r_term;

endmodule

// File: tb/tb_rtable_gen.sv
// tb_rtable_gen: directed bench for rtable_gen; one king-move 8x8 build and one rook-move
// 16x16 build sharing clock and reset.
module tb_rtable_gen;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  rtable_gen_if #(.COORD_W(3), .ACT_W(3), .DATA_WIDTH(32), .NUM_CH(2)) bus8 ();
  rtable_gen_if #(.COORD_W(4), .ACT_W(2), .DATA_WIDTH(32), .NUM_CH(2)) bus4 ();

  rtable_gen #(
    .COORD_W(3), .NUM_ACT(8), .ACT_W(3), .DATA_WIDTH(32), .NUM_CH(2)
  ) dut8 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus8)
  );

  rtable_gen #(
    .COORD_W(4), .NUM_ACT(4), .ACT_W(2), .DATA_WIDTH(32), .NUM_CH(2)
  ) dut4 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- 8x8 king-move build ----
  task automatic idle8();
    bus8.i_valid = '0;
  endtask

  task automatic req8(input int ch, input int x, input int y, input int a);
    bus8.i_valid[ch]          = 1'b1;
    bus8.i_state[ch*6 +: 6]   = {3'(x), 3'(y)};
    bus8.i_act[ch*3 +: 3]     = 3'(a);
  endtask

  task automatic cfg8(input int sel, input logic [31:0] data);
    bus8.i_cfg_we   = 1'b1;
    bus8.i_cfg_sel  = 3'(sel);
    bus8.i_cfg_data = data;
    tick();
    bus8.i_cfg_we   = 1'b0;
  endtask

  task automatic chk8(input string tag, input int ch, input logic [31:0] d,
                      input int nx, input int ny, input logic t);
    logic [5:0] exp_next;
    exp_next = {3'(nx), 3'(ny)};
    check({tag, ".valid"}, 64'(bus8.o_valid[ch]), 64'd1);
    check({tag, ".data"},  64'(bus8.o_data[ch*32 +: 32]), 64'(d));
    check({tag, ".next"},  64'(bus8.o_next[ch*6 +: 6]), 64'(exp_next));
    check({tag, ".term"},  64'(bus8.o_term[ch]), 64'(t));
  endtask

  task automatic one8(input string tag, input int x, input int y, input int a,
                      input logic [31:0] d, input int nx, input int ny, input logic t);
    idle8();
    req8(0, x, y, a);
    tick();
    idle8();
    tick();
    chk8(tag, 0, d, nx, ny, t);
  endtask

  // ---- 16x16 rook-move build ----
  task automatic idle4();
    bus4.i_valid = '0;
  endtask

  task automatic req4(input int ch, input int x, input int y, input int a);
    bus4.i_valid[ch]        = 1'b1;
    bus4.i_state[ch*8 +: 8] = {4'(x), 4'(y)};
    bus4.i_act[ch*2 +: 2]   = 2'(a);
  endtask

  task automatic chk4(input string tag, input int ch, input logic [31:0] d,
                      input int nx, input int ny, input logic t);
    logic [7:0] exp_next;
    exp_next = {4'(nx), 4'(ny)};
    check({tag, ".valid"}, 64'(bus4.o_valid[ch]), 64'd1);
    check({tag, ".data"},  64'(bus4.o_data[ch*32 +: 32]), 64'(d));
    check({tag, ".next"},  64'(bus4.o_next[ch*8 +: 8]), 64'(exp_next));
    check({tag, ".term"},  64'(bus4.o_term[ch]), 64'(t));
  endtask

  task automatic one4(input string tag, input int x, input int y, input int a,
                      input logic [31:0] d, input int nx, input int ny, input logic t);
    idle4();
    req4(0, x, y, a);
    tick();
    idle4();
    tick();
    chk4(tag, 0, d, nx, ny, t);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus8.i_stall = 1'b0; bus8.i_valid = '0; bus8.i_state = '0; bus8.i_act = '0;
    bus8.i_cfg_we = 1'b0; bus8.i_cfg_sel = '0; bus8.i_cfg_data = '0;
    bus4.i_stall = 1'b0; bus4.i_valid = '0; bus4.i_state = '0; bus4.i_act = '0;
    bus4.i_cfg_we = 1'b0; bus4.i_cfg_sel = '0; bus4.i_cfg_data = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst.valid8", 64'(bus8.o_valid), 64'd0);
    check("rst.data8",  64'(bus8.o_data),  64'd0);
    check("rst.next8",  64'(bus8.o_next),  64'd0);
    check("rst.term8",  64'(bus8.o_term),  64'd0);
    check("rst.valid4", 64'(bus4.o_valid), 64'd0);

    // West wall from (0,3); channel 1 idle
    one8("wall_w", 0, 3, 0, 32'hC37F_0000, 0, 3, 1'b0);
    check("wall_w.vmask", 64'(bus8.o_valid), 64'd1);

    // Default goal (7,7) reached from three directions; plain move
    one8("goal_e",  6, 7, 4, 32'h437F_0000, 7, 7, 1'b1);
    one8("goal_s",  7, 6, 6, 32'h437F_0000, 7, 7, 1'b1);
    one8("goal_se", 6, 6, 5, 32'h437F_0000, 7, 7, 1'b1);
    one8("plain",   3, 3, 4, 32'h0000_0000, 4, 3, 1'b0);

    // Obstacle at (4,3): write-cycle lookup on ch0 sees old map, next-cycle on ch1 sees new
    idle8();
    bus8.i_cfg_we = 1'b1; bus8.i_cfg_sel = 3'd5; bus8.i_cfg_data = 32'h23;
    req8(0, 3, 3, 4);
    tick();
    bus8.i_cfg_we = 1'b0;
    idle8();
    req8(1, 3, 3, 4);
    tick();
    chk8("obst_same", 0, 32'h0000_0000, 4, 3, 1'b0);
    idle8();
    tick();
    chk8("obst_next", 1, 32'hC37F_0000, 3, 3, 1'b0);
    check("obst_next.vmask", 64'(bus8.o_valid), 64'd2);

    // Move goal to (2,2) and R_GOAL to 5.0
    cfg8(4, 32'h12);
    cfg8(1, 32'h40A0_0000);
    one8("newgoal", 1, 1, 5, 32'h40A0_0000, 2, 2, 1'b1);
    one8("oldgoal", 6, 7, 4, 32'h0000_0000, 7, 7, 1'b0);

    // Two-channel stream with a 3-cycle stall and a config write during the stall
    idle8(); req8(0, 0, 0, 1); req8(1, 1, 2, 2);
    tick();
    idle8(); req8(0, 2, 3, 1); req8(1, 2, 1, 6);
    tick();
    chk8("s_c0a", 0, 32'hC37F_0000, 0, 0, 1'b0);
    chk8("s_c0b", 1, 32'h0000_0000, 1, 1, 1'b0);
    idle8(); req8(0, 3, 2, 0); req8(1, 7, 0, 3);
    tick();
    chk8("s_c1a", 0, 32'h0000_0000, 1, 2, 1'b0);
    chk8("s_c1b", 1, 32'h40A0_0000, 2, 2, 1'b1);
    bus8.i_stall = 1'b1;
    idle8(); req8(0, 0, 0, 0); req8(1, 0, 0, 0);
    bus8.i_cfg_we = 1'b1; bus8.i_cfg_sel = 3'd2; bus8.i_cfg_data = 32'h3F80_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus8.i_cfg_we = 1'b0;
      chk8("stall_a", 0, 32'h0000_0000, 1, 2, 1'b0);
      chk8("stall_b", 1, 32'h40A0_0000, 2, 2, 1'b1);
    end
    bus8.i_stall = 1'b0;
    idle8(); req8(0, 1, 3, 2); req8(1, 5, 5, 7);
    tick();
    chk8("s_c2a", 0, 32'h40A0_0000, 2, 2, 1'b1);
    chk8("s_c2b", 1, 32'hC37F_0000, 7, 0, 1'b0);
    idle8();
    tick();
    chk8("s_c3a", 0, 32'h3F80_0000, 1, 2, 1'b0);
    chk8("s_c3b", 1, 32'h3F80_0000, 4, 6, 1'b0);
    tick();
    check("s_drain", 64'(bus8.o_valid), 64'd0);

    // Clear all obstacles: (3,3)+E reaches (4,3) again with the new R_DEF
    cfg8(7, 32'h0);
    one8("clr_all", 3, 3, 4, 32'h3F80_0000, 4, 3, 1'b0);

    // Rook build on 16x16
    one4("r_wall_e", 15, 0, 2, 32'hC37F_0000, 15, 0, 1'b0);
    one4("r_wall_s", 0, 15, 3, 32'hC37F_0000, 0, 15, 1'b0);
    one4("r_north",  5, 5, 1, 32'h0000_0000, 5, 4, 1'b0);
    one4("r_goal",   14, 15, 2, 32'h437F_0000, 15, 15, 1'b1);

    // Mid-stream reset restores defaults
    bus4.i_cfg_we = 1'b1; bus4.i_cfg_sel = 3'd1; bus4.i_cfg_data = 32'h40A0_0000;
    tick();
    bus4.i_cfg_we = 1'b0;
    idle4(); req4(0, 14, 15, 2);
    tick();
    tick();
    chk4("r_pre_rst", 0, 32'h40A0_0000, 15, 15, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_rst.valid4", 64'(bus4.o_valid), 64'd0);
    check("r_rst.data4",  64'(bus4.o_data),  64'd0);
    check("r_rst.valid8", 64'(bus8.o_valid), 64'd0);
    one4("r_post_rst", 14, 15, 2, 32'h437F_0000, 15, 15, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
